// File: rtl/regfile_wb_scheduler_if.sv
// Valid/ready result channel from the multicycle mult/div unit to the
// register-file write-port scheduler.
interface regfile_wb_scheduler_if;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;

   modport master (
      output b_valid,
      output b_addr,
      output b_data,
      input  b_ready
   );

   modport slave (
      input  b_valid,
      input  b_addr,
      input  b_data,
      output b_ready
   );
endinterface : regfile_wb_scheduler_if

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file's single write port between pipeline writeback (A)
// and the mult/div unit (B), tracks pending B results and requests stalls.
module regfile_wb_scheduler #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                   CLK,
   input  logic                   rst,
   input  logic                   a_we,
   input  logic [4:0]             a_addr,
   input  logic [31:0]            a_data,
   regfile_wb_scheduler_if.slave  b_bus,
   input  logic                   iss_valid,
   input  logic [4:0]             iss_addr,
   input  logic [4:0]             q_a1,
   input  logic [4:0]             q_a2,
   output logic                   q_busy1,
   output logic                   q_busy2,
   output logic                   stall_req,
   output logic                   WE3,
   output logic [4:0]             A3,
   output logic [31:0]            WD3
);

   localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

   logic [31:0] r_pending;
   logic [31:0] w_pending_nxt;
   logic [3:0]  r_starve;
   logic [3:0]  w_starve_nxt;
   logic        r_stall_req;
   logic        w_stall_nxt;
   logic        w_a_act;
   logic        w_b_ready;
   logic        w_b_hs;

   // Writes to $0 are architecturally void, so they never claim the port.
   assign w_a_act   = a_we && (a_addr != 5'd0);
   assign w_b_ready = rst && !w_a_act;
   assign w_b_hs    = b_bus.b_valid && w_b_ready;

   assign b_bus.b_ready = w_b_ready;

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      WE3 = 1'b0;
      A3  = 5'd0;
      WD3 = 32'd0;
      if (rst) begin
         if (w_a_act) begin
            WE3 = 1'b1;
            A3  = a_addr;
            WD3 = a_data;
         end else if (b_bus.b_valid) begin
            WE3 = (b_bus.b_addr != 5'd0);
            A3  = b_bus.b_addr;
            WD3 = b_bus.b_data;
         end
      end
   end

   // Issue is applied after the clear so a same-cycle set wins.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_b_hs) begin
         w_pending_nxt[b_bus.b_addr] = 1'b0;
      end
      if (iss_valid && (iss_addr != 5'd0)) begin
         w_pending_nxt[iss_addr] = 1'b1;
      end
      w_pending_nxt[0] = 1'b0;
   end

   always_comb begin
      w_starve_nxt = r_starve;
      if (!b_bus.b_valid || w_b_hs) begin
         w_starve_nxt = 4'd0;
      end else if (r_starve < LP_STARVE_MAX) begin
         w_starve_nxt = r_starve + 4'd1;
      end
   end

   always_comb begin
      w_stall_nxt = r_stall_req;
      if (!b_bus.b_valid || w_b_hs) begin
         w_stall_nxt = 1'b0;
      end else if (w_starve_nxt == LP_STARVE_MAX) begin
         w_stall_nxt = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   // NOTE: the scoreboard is 32 flops, not a RAM, so it is reset with the rest
   // of the state; a stale pending bit would stall decode forever.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_pending   <= 32'd0;
         r_starve    <= 4'd0;
         r_stall_req <= 1'b0;
      end else begin
         r_pending   <= w_pending_nxt;
         r_starve    <= w_starve_nxt;
         r_stall_req <= w_stall_nxt;
      end
   end

   // Hazard queries see only registered state, never the same-cycle update.
   assign q_busy1   = r_pending[q_a1];
   assign q_busy2   = r_pending[q_a2];
   assign stall_req = r_stall_req;

   // A raised stall always coincides with a saturated counter.
   stall_implies_saturated : assert property (
      @(posedge CLK) disable iff (!rst) r_stall_req |-> (r_starve == LP_STARVE_MAX)
   );

endmodule : regfile_wb_scheduler

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: per-cycle comparison against a
// behavioural model plus hand-computed expectations at key points.
module tb_regfile_wb_scheduler;
   localparam int unsigned MAX = 4;

   logic        CLK = 1'b0;
   logic        rst = 1'b0;
   logic        a_we;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic [4:0]  q_a1;
   logic [4:0]  q_a2;
   logic        q_busy1;
   logic        q_busy2;
   logic        stall_req;
   logic        WE3;
   logic [4:0]  A3;
   logic [31:0] WD3;

   int total = 0;
   int bad   = 0;

   regfile_wb_scheduler_if b_if ();

   regfile_wb_scheduler #(.STARVE_MAX(MAX)) dut (
      .CLK       (CLK),
      .rst       (rst),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .b_bus     (b_if),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .q_a1      (q_a1),
      .q_a2      (q_a2),
      .q_busy1   (q_busy1),
      .q_busy2   (q_busy2),
      .stall_req (stall_req),
      .WE3       (WE3),
      .A3        (A3),
      .WD3       (WD3)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pending set, consecutive-blocked count, stall flag
   // derived as "count has reached the limit".
   bit m_pend [32];
   int m_starve = 0;

   always @(negedge CLK) begin
      logic        act;
      logic        e_ready;
      logic        e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      if (!rst) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_starve = 0;
      end
      act     = a_we && (a_addr != 5'd0);
      e_ready = rst && !act;
      e_we    = 1'b0;
      e_a3    = 5'd0;
      e_wd    = 32'd0;
      if (rst && act) begin
         e_we = 1'b1; e_a3 = a_addr; e_wd = a_data;
      end else if (rst && b_if.b_valid) begin
         e_we = (b_if.b_addr != 5'd0); e_a3 = b_if.b_addr; e_wd = b_if.b_data;
      end
      check("WE3",       32'(WE3),        32'(e_we));
      check("A3",        32'(A3),         32'(e_a3));
      check("WD3",       WD3,             e_wd);
      check("b_ready",   32'(b_if.b_ready), 32'(e_ready));
      check("q_busy1",   32'(q_busy1),    32'(m_pend[q_a1]));
      check("q_busy2",   32'(q_busy2),    32'(m_pend[q_a2]));
      check("stall_req", 32'(stall_req),  32'(m_starve == int'(MAX)));
      if (rst) begin
         if (b_if.b_valid && !e_ready)
            m_starve = (m_starve + 1 > int'(MAX)) ? int'(MAX) : m_starve + 1;
         else
            m_starve = 0;
         if (b_if.b_valid && e_ready) m_pend[b_if.b_addr] = 1'b0;
         if (iss_valid && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      a_we = 1'b0; a_addr = 5'd0; a_data = 32'd0;
      b_if.b_valid = 1'b0; b_if.b_addr = 5'd0; b_if.b_data = 32'd0;
      iss_valid = 1'b0; iss_addr = 5'd0;
   endtask

   initial begin
      idle();
      q_a1 = 5'd0;
      q_a2 = 5'd0;
      repeat (2) @(posedge CLK);
      #1 rst = 1'b1;

      // Priority: A wins, then B gets the port.
      step();
      a_we = 1'b1; a_addr = 5'd3; a_data = 32'h11;
      b_if.b_valid = 1'b1; b_if.b_addr = 5'd7; b_if.b_data = 32'hBEEF;
      #2;
      check("prio_we",    32'(WE3), 32'd1);
      check("prio_a3",    32'(A3), 32'd3);
      check("prio_wd",    WD3, 32'h11);
      check("prio_ready", 32'(b_if.b_ready), 32'd0);
      step();
      a_we = 1'b0;
      #2;
      check("b_win_a3",    32'(A3), 32'd7);
      check("b_win_wd",    WD3, 32'hBEEF);
      check("b_win_ready", 32'(b_if.b_ready), 32'd1);

      // $0 handling on both sources.
      step();
      a_we = 1'b1; a_addr = 5'd0; a_data = 32'h55;
      b_if.b_valid = 1'b1; b_if.b_addr = 5'd9; b_if.b_data = 32'h99;
      #2;
      check("z_a_we",    32'(WE3), 32'd1);
      check("z_a_a3",    32'(A3), 32'd9);
      check("z_a_wd",    WD3, 32'h99);
      check("z_a_ready", 32'(b_if.b_ready), 32'd1);
      step();
      a_we = 1'b0;
      b_if.b_addr = 5'd0; b_if.b_data = 32'h77;
      #2;
      check("z_b_we",    32'(WE3), 32'd0);
      check("z_b_ready", 32'(b_if.b_ready), 32'd1);

      // Scoreboard: set, set-wins-over-clear, clear.
      step();
      idle();
      q_a1 = 5'd12; q_a2 = 5'd12;
      iss_valid = 1'b1; iss_addr = 5'd12;
      #2;
      check("sb_same_cycle", 32'(q_busy1), 32'd0);
      step();
      iss_valid = 1'b0;
      #2;
      check("sb_set", 32'(q_busy1), 32'd1);
      step();
      iss_valid = 1'b1; iss_addr = 5'd12;
      b_if.b_valid = 1'b1; b_if.b_addr = 5'd12; b_if.b_data = 32'hC0DE;
      step();
      idle();
      #2;
      check("sb_set_wins", 32'(q_busy1), 32'd1);
      step();
      b_if.b_valid = 1'b1; b_if.b_addr = 5'd12; b_if.b_data = 32'hC1DE;
      step();
      idle();
      #2;
      check("sb_clear",  32'(q_busy1), 32'd0);
      check("sb_clear2", 32'(q_busy2), 32'd0);
      step();
      iss_valid = 1'b1; iss_addr = 5'd0; q_a1 = 5'd0;
      step();
      idle();
      #2;
      check("sb_r0", 32'(q_busy1), 32'd0);

      // Starvation: stall rises in cycle 4, drops the cycle after acceptance.
      for (int c = 0; c < 4; c++) begin
         step();
         a_we = 1'b1; a_addr = 5'd4; a_data = 32'h40 + 32'(c);
         b_if.b_valid = 1'b1; b_if.b_addr = 5'd20; b_if.b_data = 32'h2020;
         #2;
         check("starve_low", 32'(stall_req), 32'd0);
      end
      step();
      a_we = 1'b0;
      #2;
      check("starve_high",  32'(stall_req), 32'd1);
      check("starve_accept", 32'(b_if.b_ready), 32'd1);
      check("starve_a3",    32'(A3), 32'd20);
      step();
      idle();
      #2;
      check("starve_drop", 32'(stall_req), 32'd0);

      // Non-compliant pipeline keeps writing while stalled.
      for (int c = 0; c < 8; c++) begin
         step();
         a_we = 1'b1; a_addr = 5'd6; a_data = 32'h66;
         b_if.b_valid = 1'b1; b_if.b_addr = 5'd21; b_if.b_data = 32'h2121;
         #2;
         if (c >= 4) begin
            check("nc_stall", 32'(stall_req), 32'd1);
            check("nc_ready", 32'(b_if.b_ready), 32'd0);
            check("nc_a3",    32'(A3), 32'd6);
         end
      end
      step();
      a_we = 1'b0;
      step();
      idle();
      #2;
      check("nc_release", 32'(stall_req), 32'd0);

      // Reset mid-stream with r5 pending and stall raised.
      step();
      a_we = 1'b1; a_addr = 5'd1; a_data = 32'hA0;
      b_if.b_valid = 1'b1; b_if.b_addr = 5'd7; b_if.b_data = 32'h70;
      iss_valid = 1'b1; iss_addr = 5'd5; q_a1 = 5'd5;
      for (int c = 1; c < 4; c++) begin
         step();
         iss_valid = 1'b0;
      end
      step();
      #1;
      check("rst_pre_stall", 32'(stall_req), 32'd1);
      check("rst_pre_busy",  32'(q_busy1), 32'd1);
      rst = 1'b0;
      #1;
      check("rst_we",    32'(WE3), 32'd0);
      check("rst_a3",    32'(A3), 32'd0);
      check("rst_wd",    WD3, 32'd0);
      check("rst_ready", 32'(b_if.b_ready), 32'd0);
      check("rst_stall", 32'(stall_req), 32'd0);
      idle();
      step();
      rst = 1'b1;
      #2;
      check("rst_busy_after",  32'(q_busy1), 32'd0);
      check("rst_stall_after", 32'(stall_req), 32'd0);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule : tb_regfile_wb_scheduler
